// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Queue entries carry the fetch address alongside the word so decode never recomputes it.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, instruction memory, branch unit and decode.
// master = fetch sequencer side, slave = surrounding pipeline/memory side.
interface imem_fetch_ctrl_if;

    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    modport master (
        input  fetch_en,
        input  imem_rd,
        input  redirect_valid,
        input  redirect_pc,
        input  out_ready,
        output imem_addr,
        output out_valid,
        output out_instr,
        output out_pc,
        output out_fault
    );

    modport slave (
        output fetch_en,
        output imem_rd,
        output redirect_valid,
        output redirect_pc,
        output out_ready,
        input  imem_addr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_fault
    );

endinterface : imem_fetch_ctrl_if

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries with a synchronous flush used on pipeline redirects.
// The head reads as all-zero while empty so decode sees clean outputs after reset or flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_din,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic         o_full,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    fetch_entry_t    r_mem [QDEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == CW'(QDEPTH));
    assign o_empty = (r_count == '0);

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule : fetch_queue

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the memory address and queues fetched words.
// Out-of-range or misaligned fetches queue a NOP fault entry and halt until redirected.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter int          QDEPTH     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_fetch_ctrl_if.master  bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;

    logic         w_q_full;
    logic         w_q_empty;
    logic         w_pop;
    logic         w_fault;
    logic         w_fetch;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_fault = (r_pc[1:0] != 2'b00) || (r_pc[31:2] >= 30'(IMEM_WORDS));
    assign w_pop   = !w_q_empty && bus.out_ready;

    // A full queue still accepts a fetch when decode drains the head in the same cycle.
    assign w_fetch = (r_state == RUN) && bus.fetch_en && !bus.redirect_valid
                     && (!w_q_full || w_pop);

    always_comb begin
        w_push_entry.pc    = r_pc;
        w_push_entry.instr = w_fault ? NOP_INSTR : bus.imem_rd;
        w_push_entry.fault = w_fault;
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (bus.redirect_valid) begin
            w_state_next = RUN;
            w_pc_next    = bus.redirect_pc;
        end else if (w_fetch) begin
            if (w_fault) begin
                w_state_next = HALT;
            end else begin
                w_pc_next = r_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fetch),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_head  (w_head)
    );

    assign bus.imem_addr = r_pc;
    assign bus.out_valid = !w_q_empty;
    assign bus.out_instr = w_head.instr;
    assign bus.out_pc    = w_head.pc;
    assign bus.out_fault = w_head.fault;

endmodule : imem_fetch_ctrl

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed scenarios followed by randomized traffic.
// Expected entries are predicted from the fetch rules and checked by an independent monitor.
module tb_imem_fetch_ctrl;

    localparam int          QDEPTH     = 2;
    localparam int          IMEM_WORDS = 64;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .IMEM_WORDS (IMEM_WORDS),
        .QDEPTH     (QDEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: word i holds A000_0000 + i; unimplemented words return junk.
    always_comb begin
        if (bus.imem_addr < 32'(IMEM_WORDS * 4))
            bus.imem_rd = 32'hA000_0000 + (bus.imem_addr >> 2);
        else
            bus.imem_rd = 32'hDEAD_BEEF;
    end

    exp_t        exp_q[$];
    logic [31:0] m_pc;
    logic        m_halted;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 0;
    bit          chk_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_entry(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.fault = (pc % 4 != 0) || (pc >= IMEM_WORDS * 4);
        e.instr = e.fault ? NOP : 32'hA000_0000 + pc / 4;
        return e;
    endfunction

    // One clock cycle: check PC, drive inputs, predict, then commit the prediction after the edge.
    task automatic cycle(input logic fe, input logic rdy, input logic rv,
                         input logic [31:0] rpc, input logic rstn);
        bit pop_pred;
        bit fetch_pred;
        @(negedge clk);
        if (chk_en) chk("imem_addr", bus.imem_addr, m_pc);
        bus.fetch_en       = fe;
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        rst_n              = rstn;
        pop_pred   = (exp_q.size() > 0) && rdy;
        fetch_pred = rstn && !m_halted && fe && !rv && ((exp_q.size() < QDEPTH) || pop_pred);
        @(posedge clk);
        #1;
        if (!rstn) begin
            exp_q.delete();
            m_pc     = RESET_PC;
            m_halted = 0;
        end else if (rv) begin
            exp_q.delete();
            m_pc     = rpc;
            m_halted = 0;
        end else if (fetch_pred) begin
            exp_t e = model_entry(m_pc);
            exp_q.push_back(e);
            if (e.fault) m_halted = 1;
            else         m_pc = m_pc + 32'd4;
        end
    endtask

    // Monitor: samples just before each rising edge and retires handshakes against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
                if (bus.out_valid && exp_q.size() != 0) begin
                    chk("out_pc", bus.out_pc, exp_q[0].pc);
                    chk("out_instr", bus.out_instr, exp_q[0].instr);
                    chk("out_fault", 32'(bus.out_fault), 32'(exp_q[0].fault));
                    if (bus.out_ready) begin
                        $display("pop pc=%h instr=%h fault=%0d", bus.out_pc, bus.out_instr,
                                 bus.out_fault);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst_n              = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        m_pc               = RESET_PC;
        m_halted           = 0;

        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        @(negedge clk);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_instr", bus.out_instr, 32'd0);
        chk("reset out_pc", bus.out_pc, 32'd0);
        chk("reset out_fault", 32'(bus.out_fault), 32'd0);
        chk("reset imem_addr", bus.imem_addr, RESET_PC);
        mon_en = 1;
        chk_en = 1;

        // Straight-line fetch.
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 1);

        // Back-pressure from a fresh reset.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 1);

        // Redirect to 0x40 mid-stream.
        cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1);
        cycle(1, 1, 1, 32'h40, 1);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 1);

        // Range fault at the top of memory, then resume from 0.
        cycle(1, 1, 1, 32'hF8, 1);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 1);
        cycle(1, 1, 1, 32'h0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1);

        // Misaligned target.
        cycle(1, 1, 1, 32'h6, 1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 1);

        // Mid-operation reset with a full queue.
        cycle(1, 1, 1, 32'h20, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        fe;
            logic        rdy;
            logic        rv;
            logic        rstn;
            logic [31:0] rpc;
            fe   = ($urandom_range(0, 9) < 8);
            rdy  = ($urandom_range(0, 9) < 7);
            rv   = ($urandom_range(0, 99) < 8);
            rstn = ($urandom_range(0, 99) != 0);
            case ($urandom_range(0, 3))
                0:       rpc = 32'($urandom_range(0, IMEM_WORDS - 1)) << 2;
                1:       rpc = 32'hF0 + (32'($urandom_range(0, 3)) << 2);
                2:       rpc = 32'($urandom_range(0, 255)) | 32'h1;
                default: rpc = $urandom;
            endcase
            cycle(fe, rdy, rv, rpc, rstn);
        end

        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imem_fetch_ctrl

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer for the word-addressed, combinational-read instruction memory. Owns the program counter, drives the memory address every cycle, and buffers fetched words in a small queue with a valid/ready handshake toward decode. Handles pipeline redirects (branch/jump) by flushing the queue. Detects out-of-range or misaligned fetches and halts on them.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- IMEM_WORDS, 64: number of implemented memory words; word index ≥ IMEM_WORDS is a fault.
- QDEPTH, 2: fetch queue entries (power of two, ≥2).
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- fetch_en  input  1  permits new fetches; when low, the PC holds and the queue only drains.
- imem_addr  output  32  byte address to memory; equals the PC register (combinational from the register).
- imem_rd  input  32  memory read data, valid in the same cycle as imem_addr.
- redirect_valid  input  1  load a new PC and flush the queue this cycle.
- redirect_pc  input  32  redirect target byte address.
- out_valid  output  1  queue head valid.
- out_ready  input  1  decode accepts the head when out_valid is high.
- out_instr  output  32  head instruction word.
- out_pc  output  32  head instruction address.
- out_fault  output  1  head entry is a fetch fault.

## Operation
- States: RUN, HALT. Reset → RUN.
- Fetch condition (RUN only): fetch_en high, redirect_valid low, and queue not full **or** a pop occurs this cycle. On fetch, push {pc, imem_rd, fault} and set pc to pc+4 (32-bit wrap-around, no saturation).
- Fault = pc[1:0] ≠ 0 or pc[31:2] ≥ IMEM_WORDS. A faulted entry carries instr = NOP (32'h0000_0013) and fault = 1. The PC does not advance, and the state moves to HALT.
- HALT: no fetches; the queue drains normally. Leave HALT only on redirect or reset.
- Redirect (any state): on the edge, empty the queue, set pc to redirect_pc, enter RUN. Nothing is pushed in the redirect cycle. A pop occurring in the same cycle is still a legal handshake, and the popped entry is discarded by the flush.
- Pop: happens when out_valid and out_ready are both high; the head advances.
- Simultaneous push and pop when full is allowed; the count is unchanged.
- Output signals are driven from the registered queue head. out_valid = (count ≠ 0). out_instr, out_pc and out_fault are don't-care when out_valid is low, but the bench requires them to be 0 after reset.
- The head must hold stable while out_valid is high and out_ready is low.

## Timing
- Reset values:
  - pc = RESET_PC, queue empty, state RUN.
  - out_valid = 0, out_instr = 0, out_pc = 0, out_fault = 0.
  - imem_addr = RESET_PC.
- Reset cycle: no fetch.
- First instruction: rst_n rises before edge 0; the word is fetched in cycle 0 and out_valid is high in cycle 1.
- Fetch-to-output latency: 1 cycle. Sustained throughput: 1 instruction/cycle with out_ready held high.
- Redirect asserted in cycle N: out_valid is low in cycle N+1 and the target instruction appears in cycle N+2 (one-cycle bubble).
- Back-pressure: with out_ready low, the queue fills in QDEPTH cycles; after that the PC holds and imem_addr is stable.
- Reset mid-operation: takes effect on the next edge regardless of state, redirect or handshake. Reset dominates redirect.

## Structure
- Package fetch_pkg:
  - fetch_entry_t struct {pc[31:0], instr[31:0], fault}.
  - NOP_INSTR constant.
  - fetch_state_t enum {RUN, HALT}.
- Sub-module fetch_queue: a QDEPTH-deep FIFO of fetch_entry_t with push, pop, synchronous flush, full, empty and head outputs. Pointers wrap modulo QDEPTH.
- Top level holds the PC register, the state register, the fault compare and the push/pop control.

## Test plan
- Bench memory model: word i = 32'hA000_0000 + i.
- Straight-line fetch: reset, out_ready = 1, fetch_en = 1 → cycles 1..5 show out_pc 0, 4, 8, C, 10 with out_instr A000_0000..A000_0004, out_valid high continuously.
- Back-pressure: out_ready = 0 for 4 cycles after cycle 1 → the queue holds pc 0 and 4 and imem_addr stays at 8. Release → pc 0, 4, 8 appear with no duplicates or gaps.
- Redirect: redirect_pc = 0x40 in cycle 3 → out_valid low in cycle 4; cycle 5 shows out_pc 0x40 with A000_0010; the flushed entries never appear.
- Range fault: redirect to 0xF8 → entries 0xF8 and 0xFC are normal, then an entry with out_pc 0x100, out_fault = 1 and instr 0000_0013. After that, out_valid stays low and imem_addr stays at 0x100 until a redirect to 0x0 resumes fetching.
- Misaligned: redirect to 0x6 → a single fault entry with out_pc 0x6, then HALT.
- Mid-operation reset: rst_n low for 1 cycle with a full queue and out_ready = 0 → next cycle out_valid = 0 and imem_addr = RESET_PC, and fetching restarts from pc 0.
